// File: rtl/wb_cfg_master.sv
// Wishbone classic single-beat master for the XGE MAC register slave: a request FIFO
// feeds one bus cycle at a time, with timeout abort, interrupt edge pulse and error count.
module wb_cfg_master #(
   parameter int FIFO_DEPTH = 4,
   parameter int TIMEOUT    = 64
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [7:0]  req_adr,
   input  logic [31:0] req_dat,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_dat,
   output logic        rsp_err,
   output logic [7:0]  wb_adr_o,
   output logic        wb_cyc_o,
   output logic        wb_stb_o,
   output logic        wb_we_o,
   output logic [31:0] wb_dat_o,
   input  logic        wb_ack_i,
   input  logic [31:0] wb_dat_i,
   input  logic        wb_int_i,
   output logic        int_pulse,
   output logic [7:0]  err_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUS  = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Both ports use strict valid/ready: a transfer happens only at an edge where valid
   // and ready are both high; the sender holds its payload stable until then.

   state_e        state_q, state_d;
   logic [40:0]   mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic          req_ready_q, req_ready_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          cyc_q, cyc_d;
   logic          we_q, we_d;
   logic [7:0]    adr_q, adr_d;
   logic [31:0]   dat_q, dat_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_dat_q, rsp_dat_d;
   logic          rsp_err_q, rsp_err_d;
   logic [7:0]    err_cnt_q, err_cnt_d;
   logic          int_q, int_pulse_q;
   logic          push, pop, empty;
   logic [40:0]   head;

   assign push  = req_valid && req_ready_q;
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      to_cnt_d    = to_cnt_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      err_cnt_d   = err_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop      = 1'b1;
               we_d     = head[40];
               adr_d    = head[39:32];
               dat_d    = head[40] ? head[31:0] : 32'h0;
               cyc_d    = 1'b1;
               to_cnt_d = '0;
               state_d  = S_BUS;
            end
         end
         S_BUS: begin
            // An ack arriving on the timeout edge still wins.
            if (wb_ack_i) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
               rsp_err_d   = 1'b0;
               rsp_valid_d = 1'b1;
               state_d     = S_RESP;
            end else if ((TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
               cyc_d       = 1'b0;
               rsp_dat_d   = 32'h0;
               rsp_err_d   = 1'b1;
               rsp_valid_d = 1'b1;
               err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
               state_d     = S_RESP;
            end else begin
               to_cnt_d = to_cnt_q + TW'(1);
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      wr_ptr_d = wr_ptr_q + (AW+1)'(push);
      rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
      // Ready is computed from the post-edge occupancy, so a pop cannot raise it early.
      req_ready_d = !((wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                      (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]));
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         req_ready_q <= 1'b0;
         to_cnt_q    <= '0;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         adr_q       <= 8'h0;
         dat_q       <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= 32'h0;
         rsp_err_q   <= 1'b0;
         err_cnt_q   <= 8'h0;
         int_q       <= 1'b0;
         int_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         req_ready_q <= req_ready_d;
         to_cnt_q    <= to_cnt_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         err_cnt_q   <= err_cnt_d;
         int_q       <= wb_int_i;
         int_pulse_q <= wb_int_i && !int_q;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {req_we, req_adr, req_dat};
   end

   assign req_ready = req_ready_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign wb_adr_o  = adr_q;
   assign wb_cyc_o  = cyc_q;
   assign wb_stb_o  = cyc_q;
   assign wb_we_o   = we_q;
   assign wb_dat_o  = dat_q;
   assign int_pulse = int_pulse_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_wb_cfg_master.sv
// Bench for wb_cfg_master: transaction-level reference model checked every cycle,
// a simple Wishbone slave with programmable ack delay, and directed literal checks.
module tb_wb_cfg_master;

   localparam int DEPTH = 4;
   localparam int TO    = 64;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_we, rsp_ready;
   logic [7:0]  req_adr;
   logic [31:0] req_dat;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_dat;
   logic [7:0]  wb_adr;
   logic        wb_cyc, wb_stb, wb_we;
   logic [31:0] wb_dat_m;
   logic        wb_ack = 1'b0;
   logic [31:0] wb_dat_s = 32'hDEAD_BEEF;
   logic        wb_int;
   logic        int_pulse;
   logic [7:0]  err_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   bit check_en = 1'b0;

   wb_cfg_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
      .wb_clk_i(clk), .wb_rst_i(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_adr(req_adr), .req_dat(req_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .wb_adr_o(wb_adr), .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we),
      .wb_dat_o(wb_dat_m), .wb_ack_i(wb_ack), .wb_dat_i(wb_dat_s),
      .wb_int_i(wb_int), .int_pulse(int_pulse), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // ---------------- slave: acks ack_delay cycles after stb rises (0 = never)
   int          ack_delay = 2;
   logic [31:0] rdata_base = 32'h0;
   int          stb_age = 0;

   always begin
      @(posedge clk);
      #2;
      if (wb_cyc === 1'b1 && wb_stb === 1'b1) stb_age++;
      else stb_age = 0;
      wb_ack   = (ack_delay > 0) && (stb_age == ack_delay);
      wb_dat_s = wb_ack ? rdata_base + {24'h0, wb_adr} : 32'hDEAD_BEEF;
   end

   // ---------------- reference model: requests queue up; one bus transaction at a time
   typedef struct packed {
      logic        we;
      logic [7:0]  adr;
      logic [31:0] dat;
   } req_t;

   req_t        mq[$];
   req_t        cur;
   int          phase;       // 0 waiting for work, 1 transaction on bus, 2 response offered
   int          hi_cycles;
   logic        m_ready, m_cyc, m_rv, m_err, m_pulse, m_int_prev;
   logic [31:0] m_rdat;
   logic [7:0]  m_errcnt;
   logic        m_push;

   always @(posedge clk) begin
      if (rst) begin
         mq.delete();
         phase = 0; hi_cycles = 0; cur = '0;
         m_ready = 0; m_cyc = 0; m_rv = 0; m_err = 0; m_rdat = 0;
         m_errcnt = 0; m_pulse = 0; m_int_prev = 0;
      end else begin
         m_push = req_valid && m_ready;
         case (phase)
            0: if (mq.size() > 0) begin
                  cur = mq.pop_front();
                  m_cyc = 1; hi_cycles = 0; phase = 1;
               end
            1: begin
                  hi_cycles++;
                  if (wb_ack) begin
                     m_cyc = 0; m_rv = 1; m_err = 0;
                     m_rdat = cur.we ? 32'h0 : wb_dat_s;
                     phase = 2;
                  end else if (TO != 0 && hi_cycles == TO) begin
                     m_cyc = 0; m_rv = 1; m_err = 1; m_rdat = 32'h0;
                     if (m_errcnt != 8'hFF) m_errcnt++;
                     phase = 2;
                  end
               end
            default: if (rsp_ready) begin
                  m_rv = 0; phase = 0;
               end
         endcase
         if (m_push) mq.push_back({req_we, req_adr, req_dat});
         m_ready = (mq.size() != DEPTH);
         m_pulse = wb_int && !m_int_prev;
         m_int_prev = wb_int;
      end
   end

   // ---------------- compare DUT against model on every cycle
   always @(posedge clk) begin
      #1;
      if (check_en) begin
         check("req_ready", req_ready, m_ready);
         check("wb_cyc", wb_cyc, m_cyc);
         check("wb_stb", wb_stb, m_cyc);
         if (m_cyc) begin
            check("wb_adr", wb_adr, cur.adr);
            check("wb_we", wb_we, cur.we);
            check("wb_dat_o", wb_dat_m, cur.we ? cur.dat : 32'h0);
         end
         check("rsp_valid", rsp_valid, m_rv);
         if (m_rv) begin
            check("rsp_dat", rsp_dat, m_rdat);
            check("rsp_err", rsp_err, m_err);
         end
         check("int_pulse", int_pulse, m_pulse);
         check("err_cnt", err_cnt, m_errcnt);
      end
   end

   // ---------------- idle gap between transactions must be at least 2 cycles
   int   gap = 0;
   logic cyc_prev = 1'b0;
   bit   seen_tx = 1'b0;

   always @(posedge clk) begin
      #1;
      if (rst) begin
         gap = 0; seen_tx = 0;
      end else if (wb_cyc === 1'b1 && cyc_prev === 1'b0 && seen_tx) begin
         check("cyc_gap_ge2", gap >= 2, 1);
      end
      if (wb_cyc === 1'b1) begin
         gap = 0; seen_tx = 1;
      end else begin
         gap++;
      end
      cyc_prev = wb_cyc;
   end

   // ---------------- driver tasks (called 2 time units after a rising edge)
   task automatic send(input logic we, input logic [7:0] adr, input logic [31:0] dat);
      int g = 0;
      req_valid = 1; req_we = we; req_adr = adr; req_dat = dat;
      while (req_ready !== 1'b1 && g < 1000) begin
         cycles(1);
         g++;
      end
      check("send_ready_wait", req_ready, 1);
      cycles(1);
      req_valid = 0;
   endtask

   task automatic wait_rsp(input int limit);
      int g = 0;
      while (rsp_valid !== 1'b1 && g < limit) begin
         cycles(1);
         g++;
      end
      check("rsp_wait", rsp_valid, 1);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, pulses;
      rst = 1; req_valid = 0; req_we = 0; req_adr = 0; req_dat = 0;
      rsp_ready = 1; wb_int = 0;
      cycles(2);
      check_en = 1;
      check("reset_req_ready", req_ready, 0);
      check("reset_cyc", wb_cyc, 0);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_err_cnt", err_cnt, 0);
      rst = 0;
      cycles(1);
      check("ready_after_reset", req_ready, 1);

      // write with ack two cycles after stb
      ack_delay = 2;
      send(1'b1, 8'h08, 32'hA5A5_0001);
      check("w_cyc_not_yet", wb_cyc, 0);
      cycles(1);
      check("w_cyc", wb_cyc, 1);
      check("w_we", wb_we, 1);
      check("w_adr", wb_adr, 32'h08);
      check("w_dat", wb_dat_m, 32'hA5A5_0001);
      cycles(2);
      check("w_rsp_valid", rsp_valid, 1);
      check("w_rsp_err", rsp_err, 0);
      check("w_rsp_dat", rsp_dat, 32'h0);
      check("w_cyc_dropped", wb_cyc, 0);
      cycles(2);

      // read returning 0x1234_5678 from adr 0x0C
      rdata_base = 32'h1234_566C;
      send(1'b0, 8'h0C, 32'hFFFF_FFFF);
      cycles(1);
      check("r_we", wb_we, 0);
      check("r_dat_o", wb_dat_m, 32'h0);
      check("r_adr", wb_adr, 32'h0C);
      cycles(2);
      check("r_rsp_valid", rsp_valid, 1);
      check("r_rsp_dat", rsp_dat, 32'h1234_5678);
      check("r_rsp_err", rsp_err, 0);
      cycles(2);

      // backpressure: five reads pushed back-to-back while responses are stalled
      ack_delay = 1;
      rdata_base = 32'hAB00_0000;
      rsp_ready = 0;
      for (int i = 0; i < 5; i++) begin
         req_valid = 1; req_we = 0; req_adr = 8'(32'h20 + i); req_dat = 32'h0;
         cycles(1);
         if (i == 3) check("bp_ready_after_4", req_ready, 1);
      end
      req_valid = 0;
      check("bp_ready_after_5", req_ready, 0);
      rsp_ready = 1;
      for (int i = 0; i < 5; i++) begin
         wait_rsp(50);
         check("bp_rsp_order", rsp_dat, 32'hAB00_0020 + 32'(i));
         cycles(1);
      end
      cycles(2);

      // timeout: no ack at all
      ack_delay = 0;
      send(1'b0, 8'h30, 32'h0);
      cycles(1);
      n = 0;
      while (wb_cyc === 1'b1 && n < 200) begin
         cycles(1);
         n++;
      end
      check("to_cyc_high_cycles", n, 64);
      check("to_rsp_valid", rsp_valid, 1);
      check("to_rsp_err", rsp_err, 1);
      check("to_rsp_dat", rsp_dat, 32'h0);
      check("to_err_cnt_1", err_cnt, 1);
      cycles(1);
      for (int i = 1; i < 300; i++) begin
         send(1'b0, 8'h30, 32'h0);
         wait_rsp(200);
         cycles(1);
      end
      check("to_err_cnt_sat", err_cnt, 255);

      // reset while a transaction is on the bus and another is queued
      send(1'b1, 8'h40, 32'h1111_1111);
      cycles(1);
      check("rst_pre_cyc", wb_cyc, 1);
      send(1'b1, 8'h44, 32'h2222_2222);
      rst = 1;
      cycles(1);
      check("rst_cyc", wb_cyc, 0);
      check("rst_stb", wb_stb, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_err_cnt", err_cnt, 0);
      rst = 0;
      cycles(1);
      check("rst_ready_back", req_ready, 1);
      cycles(3);
      check("rst_no_cyc", wb_cyc, 0);
      check("rst_no_rsp", rsp_valid, 0);
      ack_delay = 2;
      send(1'b1, 8'h48, 32'h5A5A_5A5A);
      cycles(1);
      check("post_rst_adr", wb_adr, 32'h48);
      wait_rsp(20);
      check("post_rst_err", rsp_err, 0);
      cycles(2);

      // interrupt edge to pulse
      wb_int = 1;
      cycles(1);
      check("int_first_pulse", int_pulse, 1);
      pulses = 1;
      for (int i = 0; i < 9; i++) begin
         cycles(1);
         if (int_pulse === 1'b1) pulses++;
      end
      check("int_one_pulse", pulses, 1);
      wb_int = 0;
      cycles(3);
      wb_int = 1;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         cycles(1);
         if (int_pulse === 1'b1) pulses++;
      end
      check("int_second_pulse", pulses, 1);
      wb_int = 0;
      cycles(3);

      check_en = 0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_cfg_master.md
Name: wb_cfg_master

Overview:
- Wishbone classic-cycle master that sits directly upstream of the XGE MAC register slave.
- Accepts register read/write requests over a valid/ready port and buffers them in a small FIFO.
- Issues one single-beat Wishbone cycle per request and returns a response carrying read data and an error flag.
- Also converts the MAC interrupt level into a one-cycle pulse and counts bus timeouts.

Parameters:
- FIFO_DEPTH, 4, request FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, cycles of cyc high without ack before abort; 0 disables the timeout.

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  synchronous active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request FIFO not full
- req_we  in  1  1=write, 0=read
- req_adr  in  8  register address
- req_dat  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_dat  out  32  read data
- rsp_err  out  1  1=timeout abort
- wb_adr_o  out  8  to slave wb_adr_i
- wb_cyc_o  out  1  to slave wb_cyc_i
- wb_stb_o  out  1  to slave wb_stb_i
- wb_we_o  out  1  to slave wb_we_i
- wb_dat_o  out  32  to slave wb_dat_i
- wb_ack_i  in  1  from slave wb_ack_o
- wb_dat_i  in  32  from slave wb_dat_o
- wb_int_i  in  1  from slave wb_int_o
- int_pulse  out  1  one-cycle pulse on rising edge of wb_int_i
- err_cnt  out  8  saturating timeout count

Behaviour:
- Clock and reset: single clock wb_clk_i; reset wb_rst_i is synchronous, active-high.
- Reset values:
  - All outputs 0, except req_ready, which is 1 from the first cycle after reset.
  - FIFO is emptied, FSM goes to IDLE, timeout counter cleared, registered copy of wb_int_i cleared.
- Reset mid-operation: any in-flight cycle is abandoned. wb_cyc_o/wb_stb_o fall at the reset edge, and no response is produced for that request.
- Request port:
  - Push happens when req_valid && req_ready at a rising edge.
  - req_ready = !full, registered-equivalent; a pop in the same cycle does not raise req_ready.
  - FIFO order is strict FIFO. Pointers use log2(FIFO_DEPTH)+1 bits and wrap naturally.
- FSM IDLE:
  - If the FIFO is non-empty: pop the head; at the same edge load wb_adr_o/wb_we_o/wb_dat_o, set wb_cyc_o = wb_stb_o = 1, clear the timeout counter, go to BUS.
  - wb_dat_o = req_dat for writes, 0 for reads.
- FSM BUS:
  - Outputs are held stable.
  - Ack at an edge: drop cyc/stb at that edge, set rsp_dat = (we ? 0 : wb_dat_i), rsp_err = 0, rsp_valid = 1, go to RESP.
  - No ack and TIMEOUT != 0 and counter == TIMEOUT-1: drop cyc/stb, rsp_dat = 0, rsp_err = 1, rsp_valid = 1, increment err_cnt (saturating at 255), go to RESP.
  - Otherwise the counter increments.
  - Ack on the timeout edge is treated as success.
- FSM RESP:
  - rsp_valid/rsp_dat/rsp_err are held until rsp_ready.
  - On the handshake edge: rsp_valid = 0, go to IDLE.
- Latency:
  - Request pushed into an empty FIFO at edge k while in IDLE: cyc high after edge k+1.
  - Ack sampled at edge m: rsp_valid high after edge m.
  - wb_cyc_o is low for at least 2 cycles between consecutive transactions.
- wb_ack_i is ignored outside BUS.
- Interrupt: int_pulse = wb_int_i && !wb_int_q, registered, so it is high for exactly 1 cycle, one cycle after wb_int_i rises. A held level yields no further pulses.
- Backpressure: requests keep filling the FIFO while the FSM waits in BUS/RESP; req_ready falls when FIFO_DEPTH entries are held.

Test Plan:
- Reset, then write adr=0x08 dat=0xA5A5_0001 with slave acking 2 cycles after stb:
  - cyc/stb high the cycle after the push, with we=1, adr=0x08, dat=0xA5A5_0001.
  - rsp_valid high the cycle after ack, with rsp_err=0 and rsp_dat=0.
- Read adr=0x0C, slave returns 0x1234_5678 with ack:
  - wb_dat_o=0, wb_we_o=0.
  - rsp_dat=0x1234_5678, rsp_err=0.
- Push 5 requests back-to-back with rsp_ready=0 and FIFO_DEPTH=4:
  - req_ready falls after the 5th push (1 in BUS, 4 queued).
  - Responses come out in push order.
  - cyc stays low between transactions for at least 2 cycles.
- Read with no ack, TIMEOUT=64:
  - cyc drops after exactly 64 cycles high.
  - rsp_err=1, rsp_dat=0, err_cnt=1.
  - Repeat 300 times: err_cnt saturates at 255.
- Assert wb_rst_i for 1 cycle while in BUS:
  - cyc/stb, rsp_valid and req_ready are 0 after the edge; FIFO is empty and no response is produced.
  - req_ready is 1 the cycle after reset deasserts, and a following write completes normally.
- Raise wb_int_i and hold it for 10 cycles:
  - int_pulse is high exactly 1 cycle.
  - Lower then raise again: a second single pulse.
